weight_fetch: RTL and testbench
===============================

WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of return-data FIFO entries; power of two, minimum 2.
REQ-002 Parameter: ADDR_W, default 32, memory byte-address width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mode_in  input  OP_MODE  operating mode; sampled only on accepted start.
REQ-006 start  input  1  one-cycle pulse to begin a filter fetch.
REQ-007 abort  input  1  cancels the current fetch (controller free/flush).
REQ-008 base_addr  input  ADDR_W  byte address of first weight beat; 8-byte aligned.
REQ-009 rd_req  output  1  memory read request.
REQ-010 rd_addr  output  ADDR_W  memory read byte address.
REQ-011 rd_gnt  input  1  memory accepts the request this cycle.
REQ-012 rd_valid  input  1  read return beat; in order, no backpressure.
REQ-013 rd_data  input  64  read return data.
REQ-014 mem_req  input  1  weight buffer wants data.
REQ-015 mem_data_valid  output  1  beat offered to weight buffer.
REQ-016 weight_data  output  64  beat data to weight buffer.
REQ-017 busy  output  1  high outside IDLE.
REQ-018 done  output  1  one-cycle pulse when the last beat is delivered.

Function
REQ-019 States shall be IDLE, FETCH, DRAIN; start in IDLE moves to FETCH and latches mode, base_addr, and beat total.
REQ-020 Beat total shall be 88 for MODE1/MODE2, 20 for MODE3, 12 for MODE4.
REQ-021 A request is accepted when rd_req && rd_gnt; rd_addr then advances by 8; rd_addr holds while rd_req is high without rd_gnt.
REQ-022 rd_req shall be high only in FETCH, while issued < total and outstanding + fifo_count < FIFO_DEPTH (no overflow possible).
REQ-023 Each rd_valid beat shall be pushed into the FIFO in FETCH; outstanding shall be decremented on rd_valid and incremented on an accepted request, both in the same cycle when both occur.
REQ-024 mem_data_valid = FIFO not empty && mem_req && state==FETCH; weight_data = FIFO head, combinational from registered storage; pop when mem_data_valid.
REQ-025 When the delivered count reaches total: done pulses one cycle after the final pop, and the state returns to IDLE.
REQ-026 start while busy shall be ignored.
REQ-027 An abort in FETCH shall flush the FIFO and go to DRAIN; DRAIN discards rd_valid beats until outstanding==0, then goes to IDLE with no done.
REQ-028 An abort in IDLE shall have no effect; abort and start in the same cycle: abort wins.
REQ-029 Counters shall be 7 bits and address arithmetic shall be modulo 2^ADDR_W; wrap is not flagged.

Reset
REQ-030 On rst_n low: state IDLE, FIFO empty, all counters 0; rd_req, mem_data_valid, busy, and done are 0; rd_addr and weight_data are 0.

Configuration
REQ-031 With WEIGHT_FETCH_PERF_EN defined: add output stall_cycles (16 bits, saturating), which counts FETCH cycles where rd_req && !rd_gnt; it clears on accepted start and resets to 0.
REQ-032 Without WEIGHT_FETCH_PERF_EN: the port and counter are absent; behaviour is otherwise identical.

Structure
REQ-033 Beat-total constants (88/20/12) and the state enum shall live in the shared package alongside OP_MODE.
REQ-034 The FIFO shall be a sub-module weight_fetch_fifo (push, pop, flush, count, head), parameterised by FIFO_DEPTH.

Verification
REQ-035 MODE1, base 0x1000, rd_gnt=1, 2-cycle return latency, mem_req=1 -> 88 beats to rd_addr 0x1000..0x12B8 in order, done once, busy low after.
REQ-036 MODE4 with mem_req held low 20 cycles -> at most FIFO_DEPTH requests issued, none lost; 12 beats after mem_req rises.
REQ-037 MODE3 with rd_gnt random 50% -> rd_addr stable while ungranted, 20 beats, stall_cycles matches ungranted count (macro on).
REQ-038 Abort after 10 beats with 3 outstanding -> DRAIN consumes 3 returns, no mem_data_valid, no done, IDLE afterward; a new start works.
REQ-039 start during FETCH and start+abort together -> start ignored, abort taken.
REQ-040 rst_n asserted mid-FETCH -> all outputs 0 immediately (asynchronous reset), IDLE on release.

Source files
------------

// File: rtl/weight_fetch_pkg.sv
// rtl/weight_fetch_pkg.sv - shared types, beat totals and helpers for the weight fetch controller
package weight_fetch_pkg;

  // Filter layout selected at start; decides how many 64-bit beats to fetch
  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } op_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int CNT_W = 7;

  localparam logic [CNT_W-1:0] BEATS_MODE12 = 7'd88;
  localparam logic [CNT_W-1:0] BEATS_MODE3  = 7'd20;
  localparam logic [CNT_W-1:0] BEATS_MODE4  = 7'd12;

  function automatic logic [CNT_W-1:0] beat_total(input op_mode_t mode);
    case (mode)
      MODE3:   return BEATS_MODE3;
      MODE4:   return BEATS_MODE4;
      default: return BEATS_MODE12;
    endcase
  endfunction

endpackage

// File: rtl/weight_fetch_fifo.sv
// rtl/weight_fetch_fifo.sv - return-data FIFO with flush, registered storage and combinational head
module weight_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic [W-1:0]   data_i,
  input  logic           pop_i,
  input  logic           flush_i,
  output logic [PTR_W:0] count_o,
  output logic           empty_o,
  output logic [W-1:0]   head_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;

  // Occupancy after this cycle's push/pop; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    count_d = count_q;
    if (push_i) count_d = count_d + {{PTR_W{1'b0}}, 1'b1};
    if (pop_i)  count_d = count_d - {{PTR_W{1'b0}}, 1'b1};
  end

  // Storage and pointers; flush empties the queue but leaves stale entries in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/weight_fetch.sv
// rtl/weight_fetch.sv - filter weight fetch controller; WEIGHT_FETCH_PERF_EN adds the stall_cycles counter
module weight_fetch
  import weight_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  op_mode_t          mode_in,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [63:0]       rd_data,
  input  logic              mem_req,
  output logic              mem_data_valid,
  output logic [63:0]       weight_data,
  output logic              busy,
  output logic              done
`ifdef WEIGHT_FETCH_PERF_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;

  state_t              state_q;
  op_mode_t            mode_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [CNT_W-1:0]    issued_q;
  logic [CNT_W-1:0]    outstanding_q;
  logic [CNT_W-1:0]    outstanding_d;
  logic [CNT_W-1:0]    delivered_q;
  logic                done_q;

  logic [CNT_W-1:0]    total;
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_empty;
  logic [OCC_W-1:0]    occupancy;
  logic                accept;
  logic                ret_dec;
  logic                pop;
  logic                push;
  logic                flush;
  logic                start_acc;
  logic                last_pop;

  assign total     = beat_total(mode_q);
  // Credits: every beat in flight or parked in the FIFO holds a slot, so returns can never overflow
  assign occupancy = {1'b0, outstanding_q} + OCC_W'(fifo_count);

  assign rd_req    = (state_q == ST_FETCH) && (issued_q < total) &&
                     (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept    = rd_req && rd_gnt;
  assign ret_dec   = rd_valid && (state_q != ST_IDLE);
  assign mem_data_valid = !fifo_empty && mem_req && (state_q == ST_FETCH);
  assign pop       = mem_data_valid;
  assign push      = rd_valid && (state_q == ST_FETCH);
  assign flush     = abort && (state_q == ST_FETCH);
  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign last_pop  = pop && (delivered_q == total - 7'd1);

  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  weight_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (rd_data),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .head_o  (weight_data)
  );

  // Requests in flight: up on an accepted request, down on each return, both may happen together
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept)  outstanding_d = outstanding_d + 7'd1;
    if (ret_dec) outstanding_d = outstanding_d - 7'd1;
  end

  // Control FSM with its address/beat counters and the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE1;
      rd_addr_q     <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      delivered_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      outstanding_q <= outstanding_d;
      if (accept) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(8);
        issued_q  <= issued_q + 7'd1;
      end
      if (pop) delivered_q <= delivered_q + 7'd1;
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            state_q       <= ST_FETCH;
            mode_q        <= mode_in;
            rd_addr_q     <= base_addr;
            issued_q      <= '0;
            delivered_q   <= '0;
            outstanding_q <= '0;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state_q <= ST_DRAIN;
          end else if (last_pop) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (outstanding_d == '0) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_FETCH_PERF_EN
  logic [15:0] stall_q;

  // Saturating count of request cycles the memory refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (rd_req && !rd_gnt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_weight_fetch.sv
// tb/tb_weight_fetch.sv - self-checking bench for weight_fetch (directed vectors plus corner sequences)
module tb_weight_fetch;
  import weight_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  op_mode_t    mode_in;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        mem_req;
  logic        mem_data_valid;
  logic [63:0] weight_data;
  logic        busy;
  logic        done;
`ifdef WEIGHT_FETCH_PERF_EN
  logic [15:0] stall_cycles;
`endif

  weight_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode_in        (mode_in),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .mem_req        (mem_req),
    .mem_data_valid (mem_data_valid),
    .weight_data    (weight_data),
    .busy           (busy),
    .done           (done)
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, bit ok, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // Memory and weight-buffer model state
  int          cyc = 0;
  int          lat = 2;
  bit          gnt_rand = 1'b0;
  bit          gnt_val  = 1'b1;
  bit          draining = 1'b0;
  int          ret_due[$];
  logic [63:0] ret_data[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_beat;
  logic [31:0] exp_addr, last_addr, prev_addr;
  bit          prev_stall = 1'b0;
  int          accepted, returned, delivered, done_cnt, stall_cnt, dv_in_drain, last_pop_cyc;

  task automatic clear_model();
    accepted = 0; returned = 0; delivered = 0; done_cnt = 0;
    stall_cnt = 0; dv_in_drain = 0; last_pop_cyc = -10;
  endtask

  // Memory responder and output monitor: drive at the falling edge, sample 1 time unit later
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      ret_due.delete(); ret_data.delete(); exp_q.delete();
      rd_valid = 1'b0; rd_data = '0; rd_gnt = 1'b0; prev_stall = 1'b0;
    end else begin
      if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
        rd_valid = 1'b1;
        rd_data  = ret_data.pop_front();
        void'(ret_due.pop_front());
        returned++;
        if (!draining) exp_q.push_back(rd_data);
      end else begin
        rd_valid = 1'b0;
        rd_data  = '0;
      end
      rd_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_val;
      #1;
      if (rd_req) begin
        if (prev_stall) chk("rd_addr_hold", rd_addr == prev_addr, rd_addr, prev_addr);
        if (rd_gnt) begin
          chk("rd_addr", rd_addr == exp_addr, rd_addr, exp_addr);
          ret_due.push_back(cyc + lat);
          ret_data.push_back({rd_addr, ~rd_addr});
          last_addr = rd_addr;
          exp_addr  = exp_addr + 32'd8;
          accepted++;
        end else begin
          stall_cnt++;
        end
      end
      prev_stall = rd_req && !rd_gnt;
      prev_addr  = rd_addr;
      if (mem_data_valid) begin
        if (draining) begin
          dv_in_drain++;
        end else if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1'b0, weight_data, 64'h0);
        end else begin
          exp_beat = exp_q.pop_front();
          chk("weight_data", weight_data == exp_beat, weight_data, exp_beat);
          delivered++;
          last_pop_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_pop", cyc == last_pop_cyc + 1, 64'(cyc), 64'(last_pop_cyc + 1));
        chk("busy_low_with_done", busy == 1'b0, 64'(busy), 64'h0);
      end
    end
  end

  typedef struct {
    op_mode_t    mode;
    logic [31:0] base;
    int          mreq_delay;
    bit          grand;
    int          restart;
    int          beats;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[6];

  task automatic begin_fetch(input op_mode_t m, input logic [31:0] b, input bit mr);
    @(negedge clk);
    clear_model();
    exp_addr  = b;
    mode_in   = m;
    base_addr = b;
    mem_req   = mr;
    start     = 1'b1;
  endtask

  // One complete fetch; optional second start mid-fetch must be ignored
  task automatic run_txn(input vec_t v);
    bit got_done;
    gnt_rand = v.grand;
    gnt_val  = 1'b1;
    begin_fetch(v.mode, v.base, v.mreq_delay == 0);
    got_done = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      @(negedge clk);
      start = (v.restart != 0) && (c == v.restart);
      if (start) begin
        mode_in   = MODE1;
        base_addr = 32'h9000;
      end
      if (v.mreq_delay != 0 && c == v.mreq_delay) begin
        chk("reqs_while_mem_req_low", accepted <= DEPTH, 64'(accepted), 64'(DEPTH));
        chk("beats_while_mem_req_low", delivered == 0, 64'(delivered), 64'h0);
        mem_req = 1'b1;
      end
      #2;
      got_done = (done_cnt != 0);
    end
    chk("done_seen", got_done, 64'(got_done), 64'h1);
    @(negedge clk);
    #2;
    chk("beats_delivered", delivered == v.beats, 64'(delivered), 64'(v.beats));
    chk("reqs_accepted", accepted == v.beats, 64'(accepted), 64'(v.beats));
    chk("last_rd_addr", last_addr == v.last, 64'(last_addr), 64'(v.last));
    chk("done_once", done_cnt == 1, 64'(done_cnt), 64'h1);
    chk("busy_after", busy == 1'b0, 64'(busy), 64'h0);
`ifdef WEIGHT_FETCH_PERF_EN
    chk("stall_cycles", stall_cycles == 16'(stall_cnt), 64'(stall_cycles), 64'(stall_cnt));
`endif
    gnt_rand = 1'b0;
    mem_req  = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_req"}, rd_req == 1'b0, 64'(rd_req), 64'h0);
    chk({tag, "_mem_data_valid"}, mem_data_valid == 1'b0, 64'(mem_data_valid), 64'h0);
    chk({tag, "_busy"}, busy == 1'b0, 64'(busy), 64'h0);
    chk({tag, "_done"}, done == 1'b0, 64'(done), 64'h0);
    chk({tag, "_rd_addr"}, rd_addr == 32'h0, 64'(rd_addr), 64'h0);
    chk({tag, "_weight_data"}, weight_data == 64'h0, weight_data, 64'h0);
  endtask

  int drain_exp, ret_mark;

  initial begin
    vecs[0] = '{MODE1, 32'h0000_1000, 0,  1'b0, 0, 88, 32'h0000_12B8};
    vecs[1] = '{MODE2, 32'h0000_2000, 0,  1'b0, 0, 88, 32'h0000_22B8};
    vecs[2] = '{MODE3, 32'h0000_3000, 0,  1'b1, 0, 20, 32'h0000_3098};
    vecs[3] = '{MODE4, 32'h0000_4000, 20, 1'b0, 0, 12, 32'h0000_4058};
    vecs[4] = '{MODE4, 32'hFFFF_FFF0, 0,  1'b0, 0, 12, 32'h0000_0048};
    vecs[5] = '{MODE4, 32'h0000_7000, 0,  1'b0, 3, 12, 32'h0000_7058};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_req = 1'b0;
    mode_in = MODE1; base_addr = '0;
    clear_model();
    exp_addr = '0; last_addr = '0; prev_addr = '0;
    repeat (3) @(negedge clk);
    #2;
    chk_outputs_zero("reset");
`ifdef WEIGHT_FETCH_PERF_EN
    chk("reset_stall_cycles", stall_cycles == 16'h0, 64'(stall_cycles), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Abort mid-fetch with start in the same cycle: abort taken, drain swallows returns
    lat = 3;
    begin_fetch(MODE1, 32'h5000, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #2;
      if (delivered >= 10) break;
    end
    chk("abort_setup_beats", delivered >= 10, 64'(delivered), 64'd10);
    @(negedge clk);
    abort = 1'b1; start = 1'b1; mode_in = MODE4; base_addr = 32'h9000;
    @(posedge clk);
    draining  = 1'b1;
    exp_q.delete();
    drain_exp = accepted - returned;
    ret_mark  = returned;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    #2;
    chk("drain_busy", busy == 1'b1, 64'(busy), 64'h1);
    chk("drain_no_req", rd_req == 1'b0, 64'(rd_req), 64'h0);
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      @(negedge clk);
      #2;
    end
    chk("drain_idle", busy == 1'b0, 64'(busy), 64'h0);
    chk("drain_returns", (returned - ret_mark) == drain_exp, 64'(returned - ret_mark), 64'(drain_exp));
    chk("drain_no_data_valid", dv_in_drain == 0, 64'(dv_in_drain), 64'h0);
    chk("abort_no_done", done_cnt == 0, 64'(done_cnt), 64'h0);
    repeat (4) @(negedge clk);
    chk("drain_queue_empty", ret_due.size() == 0, 64'(ret_due.size()), 64'h0);
    draining = 1'b0;
    lat = 2;
    run_txn('{MODE4, 32'h0000_6000, 0, 1'b0, 0, 12, 32'h0000_6058});

    // start and abort together in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; abort = 1'b1; mode_in = MODE1; base_addr = 32'hB000;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #2;
    chk("start_abort_idle_busy", busy == 1'b0, 64'(busy), 64'h0);
    chk("start_abort_idle_req", rd_req == 1'b0, 64'(rd_req), 64'h0);

    // Asynchronous reset in the middle of a fetch
    begin_fetch(MODE1, 32'h8000, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    chk("pre_reset_busy", busy == 1'b1, 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("post_reset_idle", busy == 1'b0, 64'(busy), 64'h0);
    run_txn('{MODE3, 32'h0000_A000, 0, 1'b0, 0, 20, 32'h0000_A098});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
